// File: rtl/spi_target_if.sv
// rtl/spi_target_if.sv - SPI pin and host-side buffer signals of spi_target
interface spi_target_if;

  // SPI pins
  logic       sclk;
  logic       ssn;
  logic       mosi;
  logic       miso;

  // transmit side
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_pend;

  // receive side
  logic [7:0] rx_data;
  logic       rx_full;
  logic       rx_read;
  logic       overrun;

  // status
  logic       busy;

  // initiator + host side: drives the SPI pins and the host strobes
  modport master (
    output sclk,
    output ssn,
    output mosi,
    output tx_data,
    output tx_load,
    output rx_read,
    input  miso,
    input  tx_pend,
    input  rx_data,
    input  rx_full,
    input  overrun,
    input  busy
  );

  // the target itself
  modport slave (
    input  sclk,
    input  ssn,
    input  mosi,
    input  tx_data,
    input  tx_load,
    input  rx_read,
    output miso,
    output tx_pend,
    output rx_data,
    output rx_full,
    output overrun,
    output busy
  );

endinterface

// File: rtl/spi_target.sv
// rtl/spi_target.sv - SPI mode-0 target with one-byte TX buffer and RX holding register
// Optional: define SPI_TARGET_LSB_FIRST_EN to shift both directions LSB-first (default MSB-first).
module spi_target (
  input  logic        clk,
  input  logic        rst_n,
  spi_target_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;

  // synchronizer chains; the third sclk/ssn stage is the edge reference
  logic       sclk_s1, sclk_s2, sclk_s3;
  logic       ssn_s1,  ssn_s2,  ssn_s3;
  logic       mosi_s1, mosi_s2;

  logic       sclk_rise;
  logic       sclk_fall;
  logic       ssn_fall;
  logic       ssn_rise;

  // shift datapath
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift;
  logic [7:0] rx_next;
  logic [7:0] tx_shift;
  logic [7:0] tx_adv;
  logic       tx_bit;
  logic       reload_due;

  // buffers visible to the host
  logic [7:0] tx_buf;
  logic       tx_pend_q;
  logic [7:0] rx_data_q;
  logic       rx_full_q;
  logic       overrun_q;

  // qualified events
  logic       start;
  logic       stop;
  logic       shifting;
  logic       byte_done;
  logic       tx_step;
  logic       reload;
  logic [7:0] reload_val;

  // Bring the asynchronous SPI pins into the clk domain; ssn idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      ssn_s1  <= 1'b1;
      ssn_s2  <= 1'b1;
      ssn_s3  <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= bus.sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      ssn_s1  <= bus.ssn;
      ssn_s2  <= ssn_s1;
      ssn_s3  <= ssn_s2;
      mosi_s1 <= bus.mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign sclk_fall = ~sclk_s2 & sclk_s3;
  assign ssn_fall  = ~ssn_s2 & ssn_s3;
  assign ssn_rise  = ssn_s2 & ~ssn_s3;

  // Bit order is the only thing the configuration macro changes.
`ifdef SPI_TARGET_LSB_FIRST_EN
  assign rx_next = {mosi_s2, rx_shift[7:1]};
  assign tx_adv  = {1'b0, tx_shift[7:1]};
  assign tx_bit  = tx_shift[0];
`else
  assign rx_next = {rx_shift[6:0], mosi_s2};
  assign tx_adv  = {tx_shift[6:0], 1'b0};
  assign tx_bit  = tx_shift[7];
`endif

  // Event qualification: sclk edges are ignored in the select/deselect cycles.
  assign start      = (state == IDLE) && ssn_fall;
  assign stop       = (state == SHIFT) && ssn_rise;
  assign shifting   = (state == SHIFT) && !ssn_rise;
  assign byte_done  = shifting && sclk_rise && (bit_cnt == 3'd7);
  assign tx_step    = shifting && sclk_fall;
  assign reload     = start || (tx_step && reload_due);
  assign reload_val = tx_pend_q ? tx_buf : 8'h00;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: select starts a frame, deselect ends it wherever it is.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ssn_fall) state_nxt = SHIFT;
      SHIFT:   if (ssn_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: miso only driven while selected; host-side registers exported.
  always_comb begin
    bus.busy    = (state == SHIFT);
    bus.miso    = (state == SHIFT) ? tx_bit : 1'b0;
    bus.tx_pend = tx_pend_q;
    bus.rx_data = rx_data_q;
    bus.rx_full = rx_full_q;
    bus.overrun = overrun_q;
  end

  // Shift datapath: sample on sclk rise, advance/reload TX on sclk fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= 3'd0;
      rx_shift   <= 8'h00;
      tx_shift   <= 8'h00;
      reload_due <= 1'b0;
    end else if (start) begin
      bit_cnt    <= 3'd0;
      rx_shift   <= 8'h00;
      tx_shift   <= reload_val;
      reload_due <= 1'b0;
    end else if (stop) begin
      // a partial byte is simply dropped
      bit_cnt    <= 3'd0;
      rx_shift   <= 8'h00;
      reload_due <= 1'b0;
    end else if (shifting) begin
      if (sclk_rise) begin
        rx_shift <= rx_next;
        bit_cnt  <= bit_cnt + 3'd1;
        // the next falling edge starts the following byte
        if (bit_cnt == 3'd7) begin
          reload_due <= 1'b1;
        end
      end
      if (sclk_fall) begin
        if (reload_due) begin
          tx_shift   <= reload_val;
          reload_due <= 1'b0;
        end else begin
          tx_shift   <= tx_adv;
        end
      end
    end
  end

  // TX buffer: a host load wins over a simultaneous reload, which still
  // takes the previous buffer contents through reload_val.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_buf    <= 8'h00;
      tx_pend_q <= 1'b0;
    end else if (bus.tx_load) begin
      tx_buf    <= bus.tx_data;
      tx_pend_q <= 1'b1;
    end else if (reload) begin
      tx_pend_q <= 1'b0;
    end
  end

  // RX holding register, full flag and sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q <= 8'h00;
      rx_full_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (byte_done) begin
        rx_data_q <= rx_next;
        rx_full_q <= 1'b1;
      end else if (bus.rx_read) begin
        rx_full_q <= 1'b0;
      end
      // a read in the completion cycle counts as consuming the old byte
      if (byte_done && rx_full_q && !bus.rx_read) begin
        overrun_q <= 1'b1;
      end else if (bus.rx_read) begin
        overrun_q <= 1'b0;
      end
    end
  end

endmodule
